sid_frame_sched: RTL
====================

// Module: sid_frame_sched
// PURPOSE
//   Frame scheduler between host register-frame source and sid_glue bus writer. Host fills back bank
//   of a ping-pong 2x25-byte SID register buffer; on each frame tick a committed frame is swapped to
//   front bank and sid_glue is started to stream it. Reports underrun/overrun to firmware/LED.
// PARAMETERS
//   NREGS      25      SID registers per frame (addresses 0..NREGS-1)
//   TICK_DIV   320000  clk cycles per frame tick (16 MHz / 50 Hz PAL)
//   TIMEOUT    65535   max clk cycles from frame_start to frame_done before abort
//   REPEAT     1       1: replay front bank on tick with no new commit; 0: skip tick
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   host_we      in   1   write host_data to back bank at host_addr
//   host_addr    in   5   back-bank register address
//   host_data    in   8   register value
//   host_commit  in   1   pulse: back bank holds a complete frame
//   glue_addr    in   5   sid_glue read address (front bank)
//   ram_out      out  8   front-bank data, registered, 1-cycle latency
//   frame_start  out  1   one-cycle pulse to sid_glue data_rdy
//   frame_done   in   1   one-cycle pulse: sid_glue finished last register
//   pending      out  1   committed frame waiting for tick
//   busy         out  1   frame in flight (START or PLAY)
//   underrun_cnt out  8   ticks with no new frame, saturates at 255
//   overrun      out  1   sticky: tick arrived while busy or timeout hit; cleared by rst only
//   led_d1       out  1   = overrun | (underrun_cnt != 0)
// BEHAVIOUR
//   Reset: all outputs 0, front bank = 0, tick counter = 0, state IDLE, bank contents undefined.
//   Tick: counter counts 0..TICK_DIV-1; tick asserted one cycle at wrap; free-running, never paused.
//   Host writes: host_addr >= NREGS ignored. Writes always target back bank, also while busy.
//   Commit: sets pending. Commit while pending: frame replaced, pending stays 1, no error.
//     host_we and host_commit same cycle: write is included in committed frame.
//   FSM IDLE/START/PLAY:
//     IDLE, tick & pending: swap banks, clear pending, -> START.
//     IDLE, tick & !pending: underrun_cnt++ (sat.); REPEAT=1 -> START (same front bank), else stay.
//     START: frame_start=1 for exactly this cycle -> PLAY.
//     PLAY: frame_done -> IDLE; watchdog reaches TIMEOUT -> overrun=1, -> IDLE.
//     tick in START/PLAY: dropped, overrun=1, pending untouched.
//   Commit and tick same cycle in IDLE: tick evaluates pending as registered before the commit
//     (no swap if it was 0); new commit stays pending for next tick.
//   Swap: front/back select toggles; new back bank keeps data from two frames ago (firmware
//     rewrites all NREGS registers per frame).
//   ram_out: front_bank[glue_addr] registered every clk; glue_addr >= NREGS returns 0.
//   frame_done outside PLAY ignored. busy = (state != IDLE).
// STRUCTURE
//   sid_pkg: NREGS, state encoding (IDLE/START/PLAY), address width 5.
//   Sub-module sid_frame_buf: 2x NREGS x 8 array, bank select, host write port, registered read.
//   Top: tick divider, FSM, watchdog, counters.
// TESTING
//   Write regs 0..24 = 0x40+i, commit, wait tick -> frame_start pulse 1 cycle; glue_addr=5 -> ram_out 0x45 next clk.
//   No commit for 3 ticks, REPEAT=1 -> underrun_cnt=3, frame_start each tick, same data; 300 ticks -> 255.
//   Tick while PLAY (frame_done withheld) -> overrun=1, no second frame_start, pending preserved.
//   Withhold frame_done TIMEOUT cycles -> overrun=1, busy=0 at TIMEOUT+1; next tick starts normally.
//   Commit on tick cycle with pending=0 -> no swap that tick; swap and frame_start on following tick.
//   Assert rst during PLAY -> busy=0, frame_start=0, underrun_cnt=0, overrun=0 next cycle.

Source files
------------

// File: rtl/sid_frame_sched_pkg.sv
// Shared constants, FSM encoding and address helper for the SID frame scheduler.
package sid_frame_sched_pkg;

    localparam int unsigned NREGS  = 25;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned UCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    // True when the address names a real SID register slot.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < NREGS;
    endfunction

endpackage

// File: rtl/sid_frame_sched_if.sv
// Host, sid_glue and status signals of the frame scheduler.
interface sid_frame_sched_if;
    import sid_frame_sched_pkg::*;

    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_commit;
    logic [ADDR_W-1:0] glue_addr;
    logic [DATA_W-1:0] ram_out;
    logic              frame_start;
    logic              frame_done;
    logic              pending;
    logic              busy;
    logic [UCNT_W-1:0] underrun_cnt;
    logic              overrun;
    logic              led_d1;

    modport master (
        output host_we, host_addr, host_data, host_commit, glue_addr, frame_done,
        input  ram_out, frame_start, pending, busy, underrun_cnt, overrun, led_d1
    );

    modport slave (
        input  host_we, host_addr, host_data, host_commit, glue_addr, frame_done,
        output ram_out, frame_start, pending, busy, underrun_cnt, overrun, led_d1
    );

endinterface

// File: rtl/sid_frame_sched_frame_buf.sv
// Ping-pong 2 x NREGS register buffer: host writes the back bank, sid_glue reads the front bank.
module sid_frame_buf
    import sid_frame_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              swap,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2][NREGS];
    logic              front_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            front_sel <= 1'b0;
        end else if (swap) begin
            front_sel <= ~front_sel;
        end
    end

    // Storage is deliberately not reset; firmware rewrites every register each frame.
    always_ff @(posedge clk) begin
        if (we && addr_ok(wr_addr)) begin
            mem[~front_sel][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (addr_ok(rd_addr)) begin
            rd_data <= mem[front_sel][rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/sid_frame_sched.sv
// Frame scheduler: frame-tick divider, IDLE/START/PLAY sequencer with watchdog, and
// underrun/overrun reporting around a ping-pong SID register buffer.
module sid_frame_sched
    import sid_frame_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV = 320000,
    parameter int unsigned TIMEOUT  = 65535,
    parameter int unsigned REPEAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    sid_frame_sched_if.slave bus
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV + 1);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;

    state_t            state, state_nxt;
    logic              pending, pending_nxt;
    logic [UCNT_W-1:0] underrun, underrun_nxt;
    logic              overrun, overrun_nxt;
    logic [WDOG_W-1:0] wdog, wdog_nxt;
    logic              led_nxt;
    logic              swap_c;
    logic              frame_start_r, busy_r, led_r;

    // Free-running frame tick, one cycle at wrap.
    assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pending       <= 1'b0;
            underrun      <= '0;
            overrun       <= 1'b0;
            wdog          <= '0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
            led_r         <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            underrun      <= underrun_nxt;
            overrun       <= overrun_nxt;
            wdog          <= wdog_nxt;
            frame_start_r <= (state_nxt == ST_START);
            busy_r        <= (state_nxt != ST_IDLE);
            led_r         <= led_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        underrun_nxt = underrun;
        overrun_nxt  = overrun;
        wdog_nxt     = wdog;
        swap_c       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (tick_c) begin
                    if (pending) begin
                        swap_c      = 1'b1;
                        pending_nxt = 1'b0;
                        state_nxt   = ST_START;
                    end else begin
                        if (underrun != '1) begin
                            underrun_nxt = underrun + UCNT_W'(1);
                        end
                        if (REPEAT != 0) begin
                            state_nxt = ST_START;
                        end
                    end
                end
            end
            ST_START: begin
                // Watchdog counts cycles since frame_start; first PLAY cycle is 1.
                wdog_nxt  = WDOG_W'(1);
                state_nxt = ST_PLAY;
                if (tick_c) begin
                    overrun_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (tick_c) begin
                    overrun_nxt = 1'b1;
                end
                if (bus.frame_done) begin
                    state_nxt = ST_IDLE;
                end else if (wdog == WDOG_W'(TIMEOUT)) begin
                    overrun_nxt = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    wdog_nxt = wdog + WDOG_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A commit on a tick cycle lands after the tick has sampled the old pending.
        if (bus.host_commit) begin
            pending_nxt = 1'b1;
        end

        led_nxt = overrun_nxt | (underrun_nxt != '0);
    end

    assign bus.frame_start  = frame_start_r;
    assign bus.busy         = busy_r;
    assign bus.pending      = pending;
    assign bus.underrun_cnt = underrun;
    assign bus.overrun      = overrun;
    assign bus.led_d1       = led_r;

    sid_frame_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .swap    (swap_c),
        .we      (bus.host_we),
        .wr_addr (bus.host_addr),
        .wr_data (bus.host_data),
        .rd_addr (bus.glue_addr),
        .rd_data (bus.ram_out)
    );

endmodule
